// File: rtl/pfb_snap_pkg.sv
// Purpose : shared types and defaults for the PFB snapshot write sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: capture state enum, DATA_W/ADDR_W defaults, frame_len() helper.
package pfb_snap_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } snap_state_e;

  // Number of words in one captured frame for a given port-A address width.
  function automatic int unsigned frame_len(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/pfb_snap_ctrl.sv
// Purpose : arm -> wait for PFB sync -> write one frame of valid words into snapshot RAM port A -> sticky done.
// Latency : din/din_valid in cycle N show up as a port-A write in cycle N+1; all outputs registered.
// Backpressure: none; accepts one word per clock, din_valid gaps simply stall the write address.
// Ports   : clk/rst_n (async active-low); arm, sync_in, din_valid, din in;
//           bram_en_a, bram_we, bram_addr, bram_wr_data to RAM port A; busy, done, wr_count status.
module pfb_snap_ctrl
  import pfb_snap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              sync_in,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              bram_en_a,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] ARMED   = ST_ARMED;
  localparam logic [1:0] CAPTURE = ST_CAPTURE;
  localparam logic [1:0] DONE    = ST_DONE;

  localparam logic [ADDR_W:0] FRAME_LEN = (ADDR_W+1)'(frame_len(ADDR_W));
  localparam logic [ADDR_W:0] LAST_CNT  = FRAME_LEN - (ADDR_W+1)'(1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ADDR_W:0] cnt_nxt;
  logic            wr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wr_count;
    wr        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
        end
      end
      ARMED: begin
        // A word valid in the sync cycle itself is the first word of the frame.
        if (sync_in) begin
          state_nxt = CAPTURE;
          wr        = din_valid;
        end
      end
      CAPTURE: wr = din_valid;
      default: state_nxt = IDLE;
    endcase
    // The write address is the running count, so leaving on the last address
    // means the address never wraps.
    if (wr) begin
      cnt_nxt = wr_count + (ADDR_W+1)'(1);
      if (wr_count == LAST_CNT) begin
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_count     <= '0;
      bram_we      <= 1'b0;
      bram_en_a    <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_count  <= cnt_nxt;
      bram_we   <= wr;
      bram_en_a <= wr;
      if (wr) begin
        bram_addr    <= wr_count[ADDR_W-1:0];
        bram_wr_data <= din;
      end
      // Status follows the next state so it lines up with the write it describes.
      busy <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
      done <= (state_nxt == DONE);
    end
  end

endmodule
